clc_decoder_apb: RTL and testbench

APB-attached Column-Line-Code (CLC) decoder: the receive-side counterpart of the CLC encoder IP. Software writes a 40-bit CLC codeword and issues a start command. A multi-cycle state machine then performs per-row SEC-DED checking and correction, followed by column-parity double-error repair. Results are returned as 16-bit corrected data, status flags, and saturating error counters.

---
 rtl/clc_decoder_apb.sv | 132 +++++++++++++
 tb/tb_clc_decoder_apb.sv | 123 ++++++++++++
 2 files changed

// File: rtl/clc_decoder_apb.sv
// clc_decoder_apb: APB-controlled CLC codeword decoder with row SEC-DED and column-parity double-error repair
module clc_decoder_apb (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);
  typedef enum logic [2:0] {IDLE, ROW0, ROW1, ROW2, ROW3, COLFIX} state_t;
  state_t state, state_n;
  logic [31:0] cw_lo, rdata;
  logic [7:0] cw_hi;
  logic [39:0] work;
  logic [15:0] w_data, data, f_data, corr_cnt, unc_cnt;
  logic [3:0] w_dbl, dbl, d, fm, cp, m;
  logic [2:0] h, s, hp;
  logic [5:0] db, hb, pb;
  logic [4:0] a;
  logic [1:0] r;
  logic wr, rd, start, clr, busy, done, corr, unc, w_corr, is_row, p, pe, rdbl;
  logic vm, one, fix, f_unc, f_corr, unused_ok;
  assign PREADY = 1'b1;
  assign PSLVERR = 1'b0;
  assign unused_ok = ^PADDR[31:5];
  assign a = PADDR[4:0];
  assign wr = PSEL & PWRITE & PENABLE;
  assign rd = PSEL & ~PWRITE;
  assign start = wr && a == 5'h08 && PWDATA[0] && state == IDLE;
  assign clr = wr && a == 5'h08 && PWDATA[1];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? ROW0 : IDLE;
      ROW0:    state_n = ROW1;
      ROW1:    state_n = ROW2;
      ROW2:    state_n = ROW3;
      ROW3:    state_n = COLFIX;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) state <= IDLE;
    else state <= state_n;
  // per-row SEC-DED on the row selected by the current ROWn state
  assign is_row = state inside {ROW0, ROW1, ROW2, ROW3};
  assign r = state == ROW1 ? 2'd1 : state == ROW2 ? 2'd2 : state == ROW3 ? 2'd3 : 2'd0;
  assign db = {2'b00, r, 2'b00};
  assign hb = 6'd16 + 6'd3 * {4'd0, r};
  assign pb = 6'd28 + {4'd0, r};
  assign d = work[db +: 4];
  assign h = work[hb +: 3];
  assign p = work[pb];
  assign s = {d[1] ^ d[2] ^ d[3], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]} ^ h;
  assign pe = ^{d, h, p};
  assign fm = pe ? {s == 3'd7, s == 3'd6, s == 3'd5, s == 3'd3} : 4'b0;
  assign rdbl = ~pe & |s;
  // column stage: locate the two bad columns of a lone double-error row
  assign cp = w_data[3:0] ^ w_data[7:4] ^ w_data[11:8] ^ w_data[15:12];
  assign m = work[35:32] ^ cp;
  assign hp = work[18:16] ^ work[21:19] ^ work[24:22] ^ work[27:25];
  assign vm = |m | |(work[38:36] ^ hp) | (work[39] ^ ^work[31:28]);
  assign one = w_dbl != 4'd0 && (w_dbl & (w_dbl - 4'd1)) == 4'd0;
  assign fix = one && $countones(m) == 2;
  assign f_data = fix ? w_data ^ {w_dbl[3] ? m : 4'b0, w_dbl[2] ? m : 4'b0, w_dbl[1] ? m : 4'b0, w_dbl[0] ? m : 4'b0} : w_data;
  assign f_unc = |w_dbl & ~fix;
  assign f_corr = ~f_unc & (fix | w_corr | vm);
  assign rdata = a == 5'h00 ? cw_lo :
                 a == 5'h04 ? {24'd0, cw_hi} :
                 a == 5'h0C ? {24'd0, dbl, unc, corr, done, busy} :
                 a == 5'h10 ? {16'd0, data} :
                 a == 5'h14 ? {unc_cnt, corr_cnt} : 32'd0;
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      cw_lo <= '0;
      cw_hi <= '0;
      PRDATA <= '0;
      work <= '0;
      w_data <= '0;
      w_dbl <= '0;
      w_corr <= 1'b0;
      data <= '0;
      dbl <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      corr <= 1'b0;
      unc <= 1'b0;
      corr_cnt <= '0;
      unc_cnt <= '0;
    end else begin
      if (wr && a == 5'h00) cw_lo <= PWDATA;
      if (wr && a == 5'h04) cw_hi <= PWDATA[7:0];
      if (rd) PRDATA <= rdata;
      if (start) begin
        work <= {cw_hi, cw_lo};
        busy <= 1'b1;
        done <= 1'b0;
        corr <= 1'b0;
        unc <= 1'b0;
        dbl <= '0;
        w_dbl <= '0;
        w_corr <= 1'b0;
      end
      if (is_row) begin
        w_data[{r, 2'b00} +: 4] <= d ^ fm;
        if (pe) w_corr <= 1'b1;
        if (rdbl) w_dbl[r] <= 1'b1;
      end
      if (state == COLFIX) begin
        data <= f_data;
        corr <= f_corr;
        unc <= f_unc;
        dbl <= w_dbl;
        busy <= 1'b0;
        done <= 1'b1;
        corr_cnt <= corr_cnt + {15'd0, f_corr & ~&corr_cnt};
        unc_cnt <= unc_cnt + {15'd0, f_unc & ~&unc_cnt};
      end
      // clear is applied last so it beats a same-cycle completion
      if (clr) begin
        corr_cnt <= '0;
        unc_cnt <= '0;
        done <= 1'b0;
        corr <= 1'b0;
        unc <= 1'b0;
      end
    end
endmodule

// File: tb/tb_clc_decoder_apb.sv
// tb_clc_decoder_apb: directed-vector self-checking bench for clc_decoder_apb
module tb_clc_decoder_apb;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] paddr = '0, pwdata = '0, prdata, v;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0, pready, pslverr;
  int n_chk = 0, n_fail = 0, n_busy;
  clc_decoder_apb dut (
    .PCLK(clk), .PRESET(rst), .PADDR(paddr), .PWDATA(pwdata), .PSEL(psel),
    .PENABLE(penable), .PWRITE(pwrite), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic apb_wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = {27'd0, a}; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask
  task automatic apb_rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = {27'd0, a};
    @(negedge clk);
    penable = 1'b1;
    d = prdata;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_rd(a, d);
    chk(tag, d, exp);
  endtask
  task automatic decode(input logic [31:0] lo, input logic [31:0] hi);
    logic [31:0] d;
    apb_wr(5'h00, lo);
    apb_wr(5'h04, hi);
    apb_wr(5'h08, 32'h1);
    d = 32'h1;
    for (int i = 0; i < 10 && d[0]; i++) apb_rd(5'h0C, d);
    chk("busy_timeout", {31'd0, d[0]}, 32'd0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rd_chk("rst_cw_lo", 5'h00, 32'h0);
    rd_chk("rst_status", 5'h0C, 32'h0);
    rd_chk("rst_data", 5'h10, 32'h0);
    rd_chk("rst_cnt", 5'h14, 32'h0);
    chk("pready", {31'd0, pready}, 32'd1);
    chk("pslverr", {31'd0, pslverr}, 32'd0);
    apb_wr(5'h04, 32'hABCDEF00);
    rd_chk("cw_hi_mask", 5'h04, 32'h0);
    apb_wr(5'h18, 32'h12345678);
    rd_chk("bad_offset", 5'h18, 32'h0);
    decode(32'hFFFFFFFF, 32'h0);
    rd_chk("ones_data", 5'h10, 32'h0000FFFF);
    rd_chk("ones_status", 5'h0C, 32'h2);
    rd_chk("ones_cnt", 5'h14, 32'h0);
    rd_chk("ctrl_reads0", 5'h08, 32'h0);
    // single error in D[1][1]; watch busy through a continuous STATUS read
    apb_wr(5'h00, 32'h00000020);
    apb_wr(5'h04, 32'h0);
    apb_wr(5'h08, 32'h1);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 32'h0C;
    n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!prdata[0]) break;
      n_busy++;
    end
    psel = 1'b0;
    chk("busy_cycles", n_busy, 32'd5);
    rd_chk("sec_data", 5'h10, 32'h0);
    rd_chk("sec_status", 5'h0C, 32'h6);
    rd_chk("sec_cnt", 5'h14, 32'h1);
    decode(32'h00000003, 32'h0);
    rd_chk("dbl1_status", 5'h0C, 32'h16);
    rd_chk("dbl1_data", 5'h10, 32'h0);
    rd_chk("dbl1_cnt", 5'h14, 32'h2);
    decode(32'h00000033, 32'h0);
    rd_chk("dbl2_status", 5'h0C, 32'h3A);
    rd_chk("dbl2_data", 5'h10, 32'h33);
    rd_chk("dbl2_cnt", 5'h14, 32'h00010002);
    decode(32'h0, 32'h1);
    rd_chk("vchk_data", 5'h10, 32'h0);
    rd_chk("vchk_status", 5'h0C, 32'h6);
    rd_chk("vchk_cnt", 5'h14, 32'h00010003);
    apb_wr(5'h08, 32'h2);
    rd_chk("clr_cnt", 5'h14, 32'h0);
    rd_chk("clr_status", 5'h0C, 32'h0);
    // START and CW write while busy: snapshot and single decode are kept
    apb_wr(5'h00, 32'h00000020);
    apb_wr(5'h08, 32'h1);
    apb_wr(5'h08, 32'h1);
    apb_wr(5'h00, 32'h00000003);
    repeat (4) @(negedge clk);
    rd_chk("busy_start_status", 5'h0C, 32'h6);
    rd_chk("busy_start_cnt", 5'h14, 32'h1);
    rd_chk("busy_cw_lo", 5'h00, 32'h3);
    // reset in the middle of a decode
    apb_wr(5'h08, 32'h1);
    apb_wr(5'h08, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd_chk("abort_cw_lo", 5'h00, 32'h0);
    rd_chk("abort_status", 5'h0C, 32'h0);
    rd_chk("abort_data", 5'h10, 32'h0);
    rd_chk("abort_cnt", 5'h14, 32'h0);
    repeat (8) @(negedge clk);
    rd_chk("abort_idle", 5'h0C, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
